// File: rtl/rvx_spi_subordinate_pkg.sv
// Shared SPI constants for the rvx SPI blocks.
// Mode encodings are {cpol, cpha}.
package rvx_spi_subordinate_pkg;

  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

endpackage

// File: rtl/rvx_spi_input_synchronizer.sv
// Multi-stage synchronizer for asynchronous SPI pins.
// One extra delayed copy of the synchronized value yields rise and fall strobes.
module rvx_spi_input_synchronizer #(
  parameter int unsigned     WIDTH       = 3,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      dly_q <= RESET_VAL;
    end else begin
      stage_q[0] <= async_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      dly_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = stage_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~stage_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/rvx_spi_subordinate.sv
// SPI subordinate: oversampled sclk/mosi/cs, modes 0-3, MSB first, one-entry TX holding
// register and an RX data register with valid/ready handshakes.
module rvx_spi_subordinate
  import rvx_spi_subordinate_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_DATA   = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  cs_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_overrun_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  // Synchronized pins, bit order {cs, mosi, sclk}; cs resets to its idle (high) level.
  logic [2:0] pin_sync, pin_rise, pin_fall;

  rvx_spi_input_synchronizer #(
    .WIDTH       (3),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (3'b100)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i ({cs_i, mosi_i, sclk_i}),
    .sync_o  (pin_sync),
    .rise_o  (pin_rise),
    .fall_o  (pin_fall)
  );

  logic cs_sync, mosi_sync, sclk_rise, sclk_fall;
  logic unused_pin_edges;
  assign cs_sync          = pin_sync[2];
  assign mosi_sync        = pin_sync[1];
  assign sclk_rise        = pin_rise[0];
  assign sclk_fall        = pin_fall[0];
  assign unused_pin_edges = ^{pin_sync[0], pin_rise[2:1], pin_fall[2:1]};

  state_e                state_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, rx_data_q;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  rx_valid_q, rx_overrun_q, tx_underrun_q;
  logic                  first_edge_q, reload_pend_q;

  logic                  sample_edge, shift_edge, load_req;
  logic [DATA_WIDTH-1:0] load_word, rx_frame;

  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    unique case ({cpol_i, cpha_i})
      SPI_MODE_0, SPI_MODE_3: begin
        sample_edge = sclk_rise;
        shift_edge  = sclk_fall;
      end
      SPI_MODE_1, SPI_MODE_2: begin
        sample_edge = sclk_fall;
        shift_edge  = sclk_rise;
      end
      default: ;
    endcase
  end

  // A reload pulls from the holding register as it stood before this cycle's write.
  always_comb begin
    load_req = 1'b0;
    if (!cs_sync) begin
      if (state_q == StLoad) begin
        load_req = 1'b1;
      end else if (state_q == StShift && shift_edge) begin
        if (!cpha_i) load_req = reload_pend_q;
        else         load_req = (bit_cnt_q == '0) && !first_edge_q;
      end
    end
    load_word = hold_full_q ? hold_q : FILL_DATA;
    rx_frame  = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_req && hold_full_q) hold_full_d = 1'b0;
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      first_edge_q  <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= load_req && !hold_full_q;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      case (state_q)
        StIdle: begin
          bit_cnt_q  <= '0;
          rx_shift_q <= '0;
          if (!cs_sync) state_q <= StLoad;
        end
        StLoad: begin
          if (cs_sync) begin
            state_q <= StIdle;
          end else begin
            tx_shift_q    <= load_word;
            bit_cnt_q     <= '0;
            first_edge_q  <= 1'b1;
            reload_pend_q <= 1'b0;
            state_q       <= StShift;
          end
        end
        StShift: begin
          if (cs_sync) begin
            // Abort: partial frame and shifter contents are discarded.
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= rx_frame;
              if (bit_cnt_q == LastBit) begin
                bit_cnt_q     <= '0;
                reload_pend_q <= 1'b1;
                if (!rx_valid_q || rx_ready_i) begin
                  rx_data_q  <= rx_frame;
                  rx_valid_q <= 1'b1;
                end else begin
                  rx_overrun_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
            if (shift_edge) begin
              first_edge_q <= 1'b0;
              if (load_req) begin
                tx_shift_q    <= load_word;
                reload_pend_q <= 1'b0;
              end else if (!(cpha_i && first_edge_q)) begin
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign miso_o        = tx_shift_q[DATA_WIDTH-1] & ~cs_sync;
  assign miso_oe_o     = ~cs_sync;
  assign busy_o        = ~cs_sync;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;

endmodule
